// File: rtl/alu_seq_multiplier.sv
// Sequential shift-add unsigned multiplier (MUL half of the ALU).
// One partial product per cycle; the result and ID are captured into the output
// registers on the first DONE cycle and held until the output stage acknowledges.
module alu_seq_multiplier #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ID_SIZE   = 8,
    parameter int unsigned MUL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_valid_data,
    input  logic [MUL_WIDTH-1:0] a_in,
    input  logic [MUL_WIDTH-1:0] b_in,
    input  logic [ID_SIZE-1:0]   id_mul,
    output logic                 m_ready_data,
    output logic                 op_start,
    output logic [DATA_SIZE-1:0] mul_result,
    output logic [ID_SIZE-1:0]   mul_id,
    output logic                 mul_valid,
    input  logic                 mul_ack
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MUL_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic [MUL_WIDTH-1:0]   mcand;
    logic [MUL_WIDTH-1:0]   mplier;
    logic [DATA_SIZE-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ID_SIZE-1:0]     id_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ack only counts once the result is actually presented
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (m_valid_data) begin
                    state_next = S_BUSY;
                    accept     = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (mul_valid && mul_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs: ready mirrors the upcoming IDLE, op_start pulses after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready_data <= 1'b1;
            op_start     <= 1'b0;
        end else begin
            m_ready_data <= (state_next == S_IDLE);
            op_start     <= accept;
        end
    end

    // Operand latch, shift-add iteration and result capture/hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            id_q       <= '0;
            mul_result <= '0;
            mul_id     <= '0;
            mul_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand  <= a_in;
                        mplier <= b_in;
                        id_q   <= id_mul;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + (DATA_SIZE'(mcand) << cnt);
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_WIDTH'(1);
                end
                S_DONE: begin
                    if (!mul_valid) begin
                        mul_result <= acc;
                        mul_id     <= id_q;
                        mul_valid  <= 1'b1;
                    end else if (mul_ack) begin
                        mul_valid <= 1'b0;
                    end
                end
                default: begin
                    mul_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Self-checking bench for alu_seq_multiplier: scoreboard of expected products,
// popped and compared on each rising edge of mul_valid.
module tb_alu_seq_multiplier;

    localparam int unsigned DATA_SIZE = 16;
    localparam int unsigned ID_SIZE   = 8;
    localparam int unsigned MUL_WIDTH = 8;
    localparam int unsigned CNT_WIDTH = 4;

    typedef struct {
        logic [DATA_SIZE-1:0] result;
        logic [ID_SIZE-1:0]   id;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 m_valid_data;
    logic [MUL_WIDTH-1:0] a_in;
    logic [MUL_WIDTH-1:0] b_in;
    logic [ID_SIZE-1:0]   id_mul;
    logic                 m_ready_data;
    logic                 op_start;
    logic [DATA_SIZE-1:0] mul_result;
    logic [ID_SIZE-1:0]   mul_id;
    logic                 mul_valid;
    logic                 mul_ack;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic prev_valid = 1'b0;

    alu_seq_multiplier #(
        .DATA_SIZE(DATA_SIZE),
        .ID_SIZE  (ID_SIZE),
        .MUL_WIDTH(MUL_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_valid_data(m_valid_data),
        .a_in        (a_in),
        .b_in        (b_in),
        .id_mul      (id_mul),
        .m_ready_data(m_ready_data),
        .op_start    (op_start),
        .mul_result  (mul_result),
        .mul_id      (mul_id),
        .mul_valid   (mul_valid),
        .mul_ack     (mul_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard compare on each new result, plus op_start/mul_valid exclusivity
    always @(negedge clk) begin
        if (rst_n) begin
            check("op_start_vs_valid", 32'(op_start & mul_valid), 32'd0);
            if (mul_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("mul_result", 32'(mul_result), 32'(e.result));
                    check("mul_id", 32'(mul_id), 32'(e.id));
                end
            end
            prev_valid = mul_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Issue one operation from IDLE; ends at the negedge after the accepting edge
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] id);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (!m_ready_data && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_issue", 32'(m_ready_data), 32'd1);
        m_valid_data = 1'b1;
        a_in         = a;
        b_in         = b;
        id_mul       = id;
        e.result     = 16'(a) * 16'(b);
        e.id         = id;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        m_valid_data = 1'b0;
        @(negedge clk);
        check("op_start_pulse", 32'(op_start), 32'd1);
        check("ready_low_busy", 32'(m_ready_data), 32'd0);
    endtask

    // Count edges from the accepting edge until mul_valid is seen (bounded)
    task automatic wait_valid(input string tag);
        int k;
        k = 1;
        @(posedge clk);
        @(negedge clk);
        if (k == 1) check("op_start_one_cycle", 32'(op_start), 32'd0);
        while (!mul_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k), 32'd9);
    endtask

    task automatic ack_once();
        mul_ack = 1'b1;
        @(posedge clk);
        #1;
        mul_ack = 1'b0;
        @(negedge clk);
        check("valid_drop_after_ack", 32'(mul_valid), 32'd0);
        check("ready_after_ack", 32'(m_ready_data), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        m_valid_data = 1'b0;
        a_in         = '0;
        b_in         = '0;
        id_mul       = '0;
        mul_ack      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(m_ready_data), 32'd1);
        check("rst_op_start", 32'(op_start), 32'd0);
        check("rst_valid", 32'(mul_valid), 32'd0);
        check("rst_result", 32'(mul_result), 32'h0000);
        check("rst_id", 32'(mul_id), 32'h00);
        rst_n = 1'b1;

        // Basic product with a short backpressure hold
        issue(8'h0F, 8'h0F, 8'h21);
        wait_valid("latency_0f");
        repeat (3) @(negedge clk);
        check("hold_valid_0f", 32'(mul_valid), 32'd1);
        check("hold_result_0f", 32'(mul_result), 32'h00E1);
        ack_once();
        check("result_kept_idle", 32'(mul_result), 32'h00E1);

        // Ack tied high: one-cycle DONE
        mul_ack = 1'b1;
        issue(8'hFF, 8'hFF, 8'h3C);
        wait_valid("latency_ff");
        @(negedge clk);
        check("ff_valid_one_cycle", 32'(mul_valid), 32'd0);
        check("ff_ready_back", 32'(m_ready_data), 32'd1);
        check("ff_result_kept", 32'(mul_result), 32'hFE01);
        mul_ack = 1'b0;

        // Zero multiplicand: fixed latency
        issue(8'h00, 8'hA5, 8'h07);
        wait_valid("latency_zero");
        ack_once();

        // Backpressure with spurious pulses in BUSY and DONE
        issue(8'h37, 8'h59, 8'h44);
        @(negedge clk);
        m_valid_data = 1'b1;
        a_in = 8'h11; b_in = 8'h22; id_mul = 8'h99;
        @(posedge clk);
        #1;
        m_valid_data = 1'b0;
        @(negedge clk);
        check("busy_pulse_no_start", 32'(op_start), 32'd0);
        begin
            int k;
            k = 0;
            while (!mul_valid && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("bp_valid_seen", 32'(mul_valid), 32'd1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) begin
                m_valid_data = 1'b1;
                a_in = 8'h55; b_in = 8'h66; id_mul = 8'hAA;
            end
            if (i == 11) begin
                m_valid_data = 1'b0;
                check("done_pulse_no_start", 32'(op_start), 32'd0);
            end
            if (i % 5 == 4) begin
                check("bp_valid_hold", 32'(mul_valid), 32'd1);
                check("bp_result_hold", 32'(mul_result), 32'h131F);
                check("bp_id_hold", 32'(mul_id), 32'h44);
            end
        end
        m_valid_data = 1'b0;
        ack_once();

        // Reset mid-operation, then a clean operation
        issue(8'h12, 8'h34, 8'h55);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("abort_ready", 32'(m_ready_data), 32'd1);
        check("abort_op_start", 32'(op_start), 32'd0);
        check("abort_valid", 32'(mul_valid), 32'd0);
        check("abort_result", 32'(mul_result), 32'h0000);
        check("abort_id", 32'(mul_id), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'h12, 8'h34, 8'h66);
        wait_valid("latency_after_abort");
        check("final_result", 32'(mul_result), 32'h03A8);
        ack_once();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
